// File: rtl/serial_half_subtractor.sv
// Bit-serial subtractor: A - B over WIDTH bits, LSB first.
// Ripples a single borrow bit through one half-subtractor stage per accepted cycle.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; diff/borrow_out hold the last result
// S_RUN  | accepting bit pairs on bit_valid; busy high
// S_DONE | result just published; done high for one cycle
module serial_half_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] sr_shift;

    // Half-subtractor stage against the running borrow; new bit enters at the MSB
    assign d_bit    = a_bit ^ b_bit ^ br_q;
    assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    assign sr_shift = {d_bit, sr_q[WIDTH-1:1]};

    // State, datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            br_q    <= 1'b0;
            sr_q    <= '0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            br_q    <= br_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    // Next-state and datapath update; everything holds unless a transition says otherwise
    always_comb begin
        state_d = state_q;
        br_d    = br_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    br_d    = 1'b0;
                    sr_d    = '0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (bit_valid) begin
                    sr_d  = sr_shift;
                    br_d  = br_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        // Publish including the bit accepted on this edge
                        state_d = S_DONE;
                        cnt_d   = '0;
                        diff_d  = sr_shift;
                        bout_d  = br_next;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign diff       = diff_q;
    assign borrow_out = bout_q;
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_half_subtractor.sv
// Directed bench for serial_half_subtractor: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_serial_half_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         bit_valid;
    logic         a_bit;
    logic         b_bit;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int busy_cnt = 0;

    logic [W:0] exp_q[$];

    serial_half_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bit_valid  (bit_valid),
        .a_bit      (a_bit),
        .b_bit      (b_bit),
        .diff       (diff),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endfunction

    // Monitor: counts busy cycles and scores each published result
    always @(posedge clk) begin
        #1;
        if (busy) busy_cnt++;
        if (done) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_done: got done=1 with diff=0x%0h, expected no done", diff);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("diff", int'(diff), int'(e[W-1:0]));
                check("borrow_out", int'(borrow_out), int'(e[W]));
            end
        end
    end

    // Runs one frame starting at the current negedge and ends at the negedge of
    // the following IDLE cycle, so frames can be chained back-to-back.
    task automatic run_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] exp_d, input logic exp_b,
                             input int ga, input int gb, input int gl,
                             input bit start_in_done, input int mid_start_at);
        int t0;
        int gaps;
        gaps = 0;
        busy_cnt = 0;
        start = 1'b1;
        bit_valid = 1'b0;
        t0 = cyc + 1;
        exp_q.push_back({exp_b, exp_d});
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            start = (i == mid_start_at);
            bit_valid = 1'b1;
            a_bit = a[i];
            b_bit = b[i];
            if (i == ga || i == gb) begin
                for (int g = 0; g < gl; g++) begin
                    @(negedge clk);
                    start = 1'b0;
                    bit_valid = 1'b0;
                    a_bit = ~a_bit;
                    b_bit = ~b_bit;
                    gaps++;
                end
            end
        end
        @(negedge clk);
        start = start_in_done;
        bit_valid = 1'b0;
        check("done_pulse", int'(done), 1);
        check("done_latency", cyc - t0, W + gaps);
        check("busy_cycles", busy_cnt, W + gaps);
        @(negedge clk);
        start = 1'b0;
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);
        check("hold_diff", int'(diff), int'(exp_d));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bit_valid = 1'b0;
        a_bit = 1'b0;
        b_bit = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_diff", int'(diff), 0);
        check("rst_borrow", int'(borrow_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(8'h05, 8'h03, 8'h02, 1'b0, -1, -1, 0, 1'b0, -1);
        run_frame(8'h03, 8'h05, 8'hFE, 1'b1, -1, -1, 0, 1'b0, -1);
        run_frame(8'hFF, 8'h01, 8'hFE, 1'b0,  2,  5, 3, 1'b0, -1);
        run_frame(8'h00, 8'h00, 8'h00, 1'b0, -1, -1, 0, 1'b1, -1);
        run_frame(8'h80, 8'h81, 8'hFF, 1'b1, -1, -1, 0, 1'b0, -1);

        // Abort a frame after four bits with an asynchronous reset
        begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = 8'h10;
            b = 8'h20;
            start = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                start = 1'b0;
                bit_valid = 1'b1;
                a_bit = a[i];
                b_bit = b[i];
            end
            @(posedge clk);
            #3;
            check("pre_rst_busy", int'(busy), 1);
            rst = 1'b1;
            #1;
            check("async_rst_diff", int'(diff), 0);
            check("async_rst_borrow", int'(borrow_out), 0);
            check("async_rst_busy", int'(busy), 0);
            check("async_rst_done", int'(done), 0);
            bit_valid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            repeat (3) @(negedge clk);
        end

        run_frame(8'h10, 8'h20, 8'hF0, 1'b1, -1, -1, 0, 1'b0, -1);
        run_frame(8'h0A, 8'h04, 8'h06, 1'b0, -1, -1, 0, 1'b0, 3);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish by 20000, expected completion");
        $fatal(1);
    end

endmodule
